// File: rtl/tap_relay_sequencer.sv
// Break-before-make relay sequencer for the TAP-card relay drivers: ground relay
// made first and broken last, with a timed settle wait after every active phase.
module tap_relay_sequencer #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned GND_BIT   = 0,
    parameter int unsigned T_OPERATE = 5000,
    parameter int unsigned T_RELEASE = 3000,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] rel_drv,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] GND_MASK   = WIDTH'(1) << GND_BIT;
    localparam logic [CNT_W-1:0] T_OP_LOAD  = CNT_W'(T_OPERATE - 1);
    localparam logic [CNT_W-1:0] T_REL_LOAD = CNT_W'(T_RELEASE - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_BREAK,
        S_BREAK_W,
        S_GND_ON,
        S_GND_ON_W,
        S_MAKE,
        S_MAKE_W,
        S_GND_OFF,
        S_GND_OFF_W,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [WIDTH-1:0] rel_q, rel_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] brk_set, gon_set, mk_set, goff_set;
    logic             req_stable;

    always_comb begin
        brk_set  = rel_q & ~tgt_q & ~GND_MASK;
        gon_set  = tgt_q & ~rel_q & GND_MASK;
        mk_set   = tgt_q & ~rel_q & ~GND_MASK;
        goff_set = rel_q & ~tgt_q & GND_MASK;
        // Next s2 (= s1) against current s2: accepts a request two edges after
        // its first sample while still rejecting any single-cycle glitch.
        req_stable = (s1_q == s2_q);
    end

    always_comb begin
        state_d = state_q;
        s1_d    = req;
        s2_d    = s1_q;
        tgt_d   = tgt_q;
        rel_d   = rel_q;
        timer_d = timer_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_stable && (s2_q != rel_q)) begin
                    tgt_d   = s2_q;
                    busy_d  = 1'b1;
                    state_d = S_BREAK;
                end
            end
            S_BREAK: begin
                if (|brk_set) begin
                    rel_d   = rel_q & ~brk_set;
                    timer_d = T_REL_LOAD;
                    state_d = S_BREAK_W;
                end else begin
                    state_d = S_GND_ON;
                end
            end
            S_BREAK_W: begin
                if (timer_q == '0) state_d = S_GND_ON;
                else               timer_d = timer_q - CNT_W'(1);
            end
            S_GND_ON: begin
                if (|gon_set) begin
                    rel_d   = rel_q | gon_set;
                    timer_d = T_OP_LOAD;
                    state_d = S_GND_ON_W;
                end else begin
                    state_d = S_MAKE;
                end
            end
            S_GND_ON_W: begin
                if (timer_q == '0) state_d = S_MAKE;
                else               timer_d = timer_q - CNT_W'(1);
            end
            S_MAKE: begin
                if (|mk_set) begin
                    rel_d   = rel_q | mk_set;
                    timer_d = T_OP_LOAD;
                    state_d = S_MAKE_W;
                end else begin
                    state_d = S_GND_OFF;
                end
            end
            S_MAKE_W: begin
                if (timer_q == '0) state_d = S_GND_OFF;
                else               timer_d = timer_q - CNT_W'(1);
            end
            S_GND_OFF: begin
                if (|goff_set) begin
                    rel_d   = rel_q & ~goff_set;
                    timer_d = T_REL_LOAD;
                    state_d = S_GND_OFF_W;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_GND_OFF_W: begin
                if (timer_q == '0) state_d = S_DONE;
                else               timer_d = timer_q - CNT_W'(1);
            end
            S_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            s1_q    <= '0;
            s2_q    <= '0;
            tgt_q   <= '0;
            rel_q   <= '0;
            timer_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            tgt_q   <= tgt_d;
            rel_q   <= rel_d;
            timer_q <= timer_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign rel_drv = rel_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_tap_relay_sequencer.sv
// Scoreboard bench for tap_relay_sequencer: expected relay-change schedule is queued
// when a request is driven and popped as rel_drv changes.
module tb_tap_relay_sequencer;

    localparam int T_OP  = 4;
    localparam int T_REL = 3;
    localparam logic [7:0] G = 8'h01;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] rel_drv;
    logic       busy;
    logic       done;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } ev_t;
    ev_t exp_q[$];

    always #5 clk = ~clk;

    tap_relay_sequencer #(
        .WIDTH    (8),
        .GND_BIT  (0),
        .T_OPERATE(T_OP),
        .T_RELEASE(T_REL),
        .CNT_W    (16)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .rel_drv(rel_drv),
        .busy   (busy),
        .done   (done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected schedule: cycle offsets are edges after the edge where busy rises.
    task automatic plan(input logic [7:0] o, input logic [7:0] n, output int len);
        int         c;
        logic [7:0] cur, m;
        c   = 1;
        cur = o;
        m = cur & ~n & ~G;
        if (m != 0) begin cur = cur & ~m; exp_q.push_back('{c, cur}); c += T_REL + 1; end
        else c += 1;
        m = n & ~cur & G;
        if (m != 0) begin cur = cur | m; exp_q.push_back('{c, cur}); c += T_OP + 1; end
        else c += 1;
        m = n & ~cur & ~G;
        if (m != 0) begin cur = cur | m; exp_q.push_back('{c, cur}); c += T_OP + 1; end
        else c += 1;
        m = cur & ~n & G;
        if (m != 0) begin cur = cur & ~m; exp_q.push_back('{c, cur}); c += T_REL + 1; end
        else c += 1;
        len = c;
    endtask

    task automatic run_seq(input logic [7:0] o, input logic [7:0] n, input bit drive,
                           input int lat, input bit gnd_guard, input bit use_forbid,
                           input logic [7:0] forbid, input int mid_at,
                           input logic [7:0] mid_req);
        int         len, waited, bad_cyc;
        logic [7:0] prev;
        bit         guard_bad, forbid_seen;
        ev_t        e;
        exp_q.delete();
        plan(o, n, len);
        if (drive) req = n;
        waited = 0;
        do begin step(); waited++; end while (!busy && waited < 20);
        tests_run++;
        if (busy !== 1'b1 || (lat > 0 && waited != lat)) begin
            tests_failed++;
            $display("FAIL start_latency %h->%h: busy=%b after %0d edges, required 1 after %0d",
                     o, n, busy, waited, lat);
        end
        if (busy !== 1'b1) return;
        tests_run++;
        if (rel_drv !== o) begin
            tests_failed++;
            $display("FAIL start_value: rel_drv=%h required %h", rel_drv, o);
        end
        prev        = rel_drv;
        guard_bad   = 1'b0;
        forbid_seen = 1'b0;
        bad_cyc     = -1;
        for (int c = 1; c <= len; c++) begin
            step();
            if (c == mid_at) req = mid_req;
            if (rel_drv !== prev) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL unexpected_change: rel_drv=%h at cycle %0d, required no change",
                             rel_drv, c);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != c || rel_drv !== e.val) begin
                        tests_failed++;
                        $display("FAIL relay_step %h->%h: got %h at cycle %0d, required %h at cycle %0d",
                                 o, n, rel_drv, c, e.val, e.cyc);
                    end
                end
                prev = rel_drv;
            end
            if (gnd_guard && ((rel_drv & ~G) != 0) && rel_drv[0] !== 1'b1) guard_bad = 1'b1;
            if (use_forbid && rel_drv === forbid) forbid_seen = 1'b1;
            if (c < len && (busy !== 1'b1 || done !== 1'b0) && bad_cyc < 0) bad_cyc = c;
        end
        tests_run++;
        if (bad_cyc >= 0) begin
            tests_failed++;
            $display("FAIL busy_hold: busy/done wrong at cycle %0d, required busy=1 done=0 until cycle %0d",
                     bad_cyc, len);
        end
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL done_pulse: done=%b busy=%b at cycle %0d, required done=1 busy=0",
                     done, busy, len);
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL missing_change: %0d changes not seen, next required %h at cycle %0d",
                     exp_q.size(), exp_q[0].val, exp_q[0].cyc);
        end
        tests_run++;
        if (rel_drv !== n) begin
            tests_failed++;
            $display("FAIL final_value: rel_drv=%h required %h", rel_drv, n);
        end
        if (gnd_guard) begin
            tests_run++;
            if (guard_bad) begin
                tests_failed++;
                $display("FAIL gnd_order: signal relay energized with ground off, required ground on");
            end
        end
        if (use_forbid) begin
            tests_run++;
            if (forbid_seen) begin
                tests_failed++;
                $display("FAIL forbidden_pattern: rel_drv showed %h, required never", forbid);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req   = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (rel_drv !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_state: rel_drv=%h busy=%b done=%b, required 00 0 0",
                         rel_drv, busy, done);
            end
        end
        reset = 1'b1;
        run_seq(8'h00, 8'hFF, 1'b0, 3, 1'b1, 1'b0, 8'h00, -1, 8'h00);
        run_seq(8'hFF, 8'h00, 1'b1, 3, 1'b1, 1'b0, 8'h00, -1, 8'h00);
    endtask

    task automatic test_power_on_make();
        run_seq(8'h00, 8'h03, 1'b1, 3, 1'b1, 1'b0, 8'h00, -1, 8'h00);
        step();
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL done_single: done=%b busy=%b one cycle after done, required 0 0", done, busy);
        end
    endtask

    task automatic test_release();
        run_seq(8'h03, 8'h00, 1'b1, 3, 1'b1, 1'b0, 8'h00, -1, 8'h00);
    endtask

    task automatic test_swap();
        run_seq(8'h00, 8'h07, 1'b1, 3, 1'b1, 1'b0, 8'h00, -1, 8'h00);
        run_seq(8'h07, 8'h0B, 1'b1, 3, 1'b1, 1'b1, 8'h0F, -1, 8'h00);
        run_seq(8'h0B, 8'h00, 1'b1, 3, 1'b1, 1'b0, 8'h00, -1, 8'h00);
    endtask

    task automatic test_back_to_back();
        run_seq(8'h00, 8'h03, 1'b1, 3, 1'b1, 1'b0, 8'h00, 8, 8'h00);
        run_seq(8'h03, 8'h00, 1'b0, 1, 1'b1, 1'b0, 8'h00, -1, 8'h00);
    endtask

    task automatic test_glitch();
        bit seen;
        req = 8'h02;
        step();
        req  = 8'h00;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (busy !== 1'b0 || rel_drv !== 8'h00) seen = 1'b1;
        end
        tests_run++;
        if (seen) begin
            tests_failed++;
            $display("FAIL glitch_reject: busy=%b rel_drv=%h after 1-cycle pulse, required 0 00",
                     busy, rel_drv);
        end
    endtask

    task automatic test_async_reset();
        int  waited;
        bit  bad;
        req    = 8'h03;
        waited = 0;
        do begin step(); waited++; end while (!busy && waited < 20);
        step();
        step();
        tests_run++;
        if (rel_drv !== 8'h01 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL gnd_on_wait: rel_drv=%h busy=%b, required 01 1", rel_drv, busy);
        end
        #2 reset = 1'b0;
        #1;
        tests_run++;
        if (rel_drv !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: rel_drv=%h busy=%b done=%b, required 00 0 0",
                     rel_drv, busy, done);
        end
        req = 8'h00;
        step();
        step();
        reset = 1'b1;
        bad   = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (busy !== 1'b0 || rel_drv !== 8'h00) bad = 1'b1;
        end
        tests_run++;
        if (bad) begin
            tests_failed++;
            $display("FAIL no_resume: busy=%b rel_drv=%h after release, required 0 00", busy, rel_drv);
        end
    endtask

    initial begin
        test_reset();
        test_power_on_make();
        test_release();
        test_swap();
        test_back_to_back();
        test_glitch();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
